// File: rtl/i2s_tx_stereo.sv
// i2s_tx_stereo: stereo I2S / left-justified serialiser for the DAC path.
// A one-frame holding buffer accepts {L,R} pairs over valid/ready. Each lrclk
// slot shifts one channel out MSB first. Underrun and short slots are flagged.
// Optional build macro: I2S_TX_HOLD_LAST_EN. When defined, an underrun frame
// re-sends the last transmitted pair. When undefined, it sends zeros.
module i2s_tx_stereo #(
  parameter int DATA_W  = 24,
  parameter int LJ_MODE = 0
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              lrclk,
  input  logic [DATA_W-1:0] left_data,
  input  logic [DATA_W-1:0] right_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sdout,
  output logic              frame_start,
  output logic              underrun,
  output logic              slot_err
);

  localparam int               CNT_W   = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_SHIFT,
    ST_PAD
  } state_t;

  // registered state
  logic              r_lr_q;
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_right;
  logic [DATA_W-1:0] r_hold_l;
  logic [DATA_W-1:0] r_hold_r;
  logic              r_full;
  logic              r_armed;
  logic              r_sdout;
  logic              r_frame_start;
  logic              r_underrun;
  logic              r_slot_err;
`ifdef I2S_TX_HOLD_LAST_EN
  logic [DATA_W-1:0] r_last_l;
  logic [DATA_W-1:0] w_last_l_next;
`endif

  // next-state values
  state_t            w_state_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [DATA_W-1:0] w_shift_next;
  logic [DATA_W-1:0] w_right_next;
  logic [DATA_W-1:0] w_hold_l_next;
  logic [DATA_W-1:0] w_hold_r_next;
  logic              w_full_next;
  logic              w_armed_next;
  logic              w_sdout_next;
  logic              w_frame_start_next;
  logic              w_underrun_next;
  logic              w_slot_err_next;

  // edge detection and handshake
  logic w_edge;
  logic w_left_edge;
  logic w_accept;

  assign w_edge      = (lrclk != r_lr_q);
  assign w_left_edge = w_edge && !lrclk;
  assign in_ready    = ~r_full;
  assign w_accept    = in_valid && ~r_full;

  assign sdout       = r_sdout;
  assign frame_start = r_frame_start;
  assign underrun    = r_underrun;
  assign slot_err    = r_slot_err;

  // state register and datapath registers
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_lr_q        <= lrclk;
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_shift       <= '0;
      r_right       <= '0;
      r_hold_l      <= '0;
      r_hold_r      <= '0;
      r_full        <= 1'b0;
      r_armed       <= 1'b0;
      r_sdout       <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_slot_err    <= 1'b0;
    end else begin
      r_lr_q        <= lrclk;
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_shift       <= w_shift_next;
      r_right       <= w_right_next;
      r_hold_l      <= w_hold_l_next;
      r_hold_r      <= w_hold_r_next;
      r_full        <= w_full_next;
      r_armed       <= w_armed_next;
      r_sdout       <= w_sdout_next;
      r_frame_start <= w_frame_start_next;
      r_underrun    <= w_underrun_next;
      r_slot_err    <= w_slot_err_next;
    end
  end

`ifdef I2S_TX_HOLD_LAST_EN
  // remembers the last real left sample for replay on underrun
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_last_l <= '0;
    end else begin
      r_last_l <= w_last_l_next;
    end
  end
`endif

  // next-state, buffer and pulse logic
  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_shift_next       = r_shift;
    w_right_next       = r_right;
    w_hold_l_next      = r_hold_l;
    w_hold_r_next      = r_hold_r;
    w_full_next        = r_full;
    w_armed_next       = r_armed;
    w_frame_start_next = 1'b0;
    w_underrun_next    = 1'b0;
    w_slot_err_next    = 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
    w_last_l_next      = r_last_l;
`endif

    // Buffer write. A left edge below may consume the pair in the same cycle.
    if (w_accept) begin
      w_hold_l_next = left_data;
      w_hold_r_next = right_data;
      w_full_next   = 1'b1;
      w_armed_next  = 1'b1;
    end

    // Normal progress through a slot when no lrclk edge arrives.
    case (r_state)
      ST_DELAY: begin
        w_state_next = ST_SHIFT;
        w_cnt_next   = CNT_TOP;
      end
      ST_SHIFT: begin
        if (r_cnt == '0) begin
          w_state_next = ST_PAD;
        end else begin
          w_cnt_next   = r_cnt - CNT_W'(1);
          w_shift_next = {r_shift[DATA_W-2:0], 1'b0};
        end
      end
      default: begin
        w_state_next = r_state;
      end
    endcase

    // An edge always starts a new slot. The word counts as complete once its
    // LSB is on the wire, so only a pending delay bit or pending bits is an error.
    if (w_edge) begin
      w_slot_err_next = (r_state == ST_DELAY) ||
                        ((r_state == ST_SHIFT) && (r_cnt != '0));
      if (w_left_edge) begin
        w_frame_start_next = 1'b1;
        if (r_full) begin
          w_shift_next = r_hold_l;
          w_right_next = r_hold_r;
          w_full_next  = 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
          w_last_l_next = r_hold_l;
`endif
        end else if (in_valid) begin
          // empty buffer and a pair arriving now: pass it straight through
          w_shift_next = left_data;
          w_right_next = right_data;
          w_full_next  = 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
          w_last_l_next = left_data;
`endif
        end else begin
          w_underrun_next = r_armed;
`ifdef I2S_TX_HOLD_LAST_EN
          // the right register still holds the last right sample
          w_shift_next = r_last_l;
`else
          w_shift_next = '0;
          w_right_next = '0;
`endif
        end
      end else begin
        w_shift_next = r_right;
      end

      if (LJ_MODE != 0) begin
        w_state_next = ST_SHIFT;
        w_cnt_next   = CNT_TOP;
      end else begin
        w_state_next = ST_DELAY;
        w_cnt_next   = CNT_TOP;
      end
    end

    w_sdout_next = (w_state_next == ST_SHIFT) ? w_shift_next[DATA_W-1] : 1'b0;
  end

endmodule

// File: tb/tb_i2s_tx_stereo.sv
// tb_i2s_tx_stereo: directed bench for i2s_tx_stereo. It runs one Philips and
// one left-justified instance side by side on shared stimulus.
module tb_i2s_tx_stereo;

  logic        sclk;
  logic        rst;
  logic        lrclk;
  logic [23:0] left_data;
  logic [23:0] right_data;
  logic        in_valid;

  logic i2s_in_ready, i2s_sdout, i2s_frame_start, i2s_underrun, i2s_slot_err;
  logic lj_in_ready, lj_sdout, lj_frame_start, lj_underrun, lj_slot_err;

  int n_checks = 0;
  int n_errors = 0;

  logic send_pending = 1'b0;

  logic cap_i2s [0:63];
  logic cap_lj  [0:63];
  logic cap_fs  [0:63];
  logic cap_se  [0:63];
  int   fs_n, ur_n, se_n, ur_lj_n, se_lj_n;

`ifdef I2S_TX_HOLD_LAST_EN
  localparam logic [31:0] UR_L = 32'hA5A5A5;
  localparam logic [31:0] UR_R = 32'h123456;
`else
  localparam logic [31:0] UR_L = 32'h0;
  localparam logic [31:0] UR_R = 32'h0;
`endif

  i2s_tx_stereo #(.DATA_W(24), .LJ_MODE(0)) dut_i2s (
    .sclk(sclk), .rst(rst), .lrclk(lrclk),
    .left_data(left_data), .right_data(right_data), .in_valid(in_valid),
    .in_ready(i2s_in_ready), .sdout(i2s_sdout), .frame_start(i2s_frame_start),
    .underrun(i2s_underrun), .slot_err(i2s_slot_err)
  );

  i2s_tx_stereo #(.DATA_W(24), .LJ_MODE(1)) dut_lj (
    .sclk(sclk), .rst(rst), .lrclk(lrclk),
    .left_data(left_data), .right_data(right_data), .in_valid(in_valid),
    .in_ready(lj_in_ready), .sdout(lj_sdout), .frame_start(lj_frame_start),
    .underrun(lj_underrun), .slot_err(lj_slot_err)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // MSB-first assembly of n captured bits starting at index start
  function automatic logic [31:0] get_bits(input int sel, input int start, input int n);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < n; k++) begin
      v = {v[30:0], (sel == 0) ? cap_i2s[start + k] : cap_lj[start + k]};
    end
    return v;
  endfunction

  task automatic send_pair(input logic [23:0] l, input logic [23:0] r);
    left_data    = l;
    right_data   = r;
    in_valid     = 1'b1;
    send_pending = 1'b1;
  endtask

  // Drive lrclk for len cycles. Index j holds the outputs after the j-th edge.
  task automatic run_slot(input logic lr, input int len);
    logic hs;
    lrclk   = lr;
    fs_n    = 0;
    ur_n    = 0;
    se_n    = 0;
    ur_lj_n = 0;
    se_lj_n = 0;
    for (int j = 0; j < len; j++) begin
      hs = in_valid && i2s_in_ready;
      tick();
      if (send_pending && hs) begin
        send_pending = 1'b0;
        in_valid     = 1'b0;
      end
      cap_i2s[j] = i2s_sdout;
      cap_lj[j]  = lj_sdout;
      cap_fs[j]  = i2s_frame_start;
      cap_se[j]  = i2s_slot_err;
      fs_n    += int'(i2s_frame_start);
      ur_n    += int'(i2s_underrun);
      se_n    += int'(i2s_slot_err);
      ur_lj_n += int'(lj_underrun);
      se_lj_n += int'(lj_slot_err);
    end
    $display("slot lr=%0d len=%0d fs=%0d ur=%0d se=%0d ready=%0d",
             lr, len, fs_n, ur_n, se_n, i2s_in_ready);
  endtask

  initial begin
    rst        = 1'b1;
    lrclk      = 1'b0;
    left_data  = '0;
    right_data = '0;
    in_valid   = 1'b0;
    repeat (3) tick();
    check_val("rst_ready",   32'(i2s_in_ready),    32'd1);
    check_val("rst_sdout",   32'(i2s_sdout),       32'd0);
    check_val("rst_fs",      32'(i2s_frame_start), 32'd0);
    check_val("rst_ur",      32'(i2s_underrun),    32'd0);
    check_val("rst_se",      32'(i2s_slot_err),    32'd0);
    check_val("rst_lj_sd",   32'(lj_sdout),        32'd0);
    rst = 1'b0;

    // no false edge after reset with lrclk low
    run_slot(1'b0, 4);
    check_val("post_rst_fs", 32'(fs_n), 32'd0);

    // unarmed frame: frame marker only, silence, no underrun
    run_slot(1'b1, 32);
    run_slot(1'b0, 32);
    check_val("unarm_fs",    32'(fs_n), 32'd1);
    check_val("unarm_ur",    32'(ur_n), 32'd0);
    check_val("unarm_word",  get_bits(0, 0, 32), 32'h0);

    // load a pair during the right slot, then try to push a second one
    send_pair(24'hA5A5A5, 24'h123456);
    run_slot(1'b1, 16);
    check_val("full_ready",  32'(i2s_in_ready), 32'd0);
    left_data  = 24'hFFFFFF;
    right_data = 24'hFFFFFF;
    in_valid   = 1'b1;
    run_slot(1'b1, 8);
    check_val("full_block",  32'(i2s_in_ready), 32'd0);
    in_valid = 1'b0;
    run_slot(1'b1, 8);

    // first real frame
    run_slot(1'b0, 32);
    check_val("f1_fs_pos",   32'(cap_fs[0]), 32'd1);
    check_val("f1_fs_n",     32'(fs_n), 32'd1);
    check_val("f1_ur",       32'(ur_n), 32'd0);
    check_val("f1_delay",    32'(cap_i2s[0]), 32'd0);
    check_val("f1_i2s_L",    get_bits(0, 1, 24), 32'hA5A5A5);
    check_val("f1_i2s_pad",  get_bits(0, 25, 7), 32'h0);
    check_val("f1_lj_L",     get_bits(1, 0, 24), 32'hA5A5A5);
    check_val("f1_lj_pad",   get_bits(1, 24, 8), 32'h0);
    check_val("f1_ready",    32'(i2s_in_ready), 32'd1);
    run_slot(1'b1, 32);
    check_val("f1_r_fs",     32'(fs_n), 32'd0);
    check_val("f1_i2s_R",    get_bits(0, 1, 24), 32'h123456);
    check_val("f1_lj_R",     get_bits(1, 0, 24), 32'h123456);
    check_val("f1_se",       32'(se_n), 32'd0);

    // starved frames
    for (int f = 0; f < 2; f++) begin
      run_slot(1'b0, 32);
      check_val("ur_pulse",  32'(ur_n), 32'd1);
      check_val("ur_lj",     32'(ur_lj_n), 32'd1);
      check_val("ur_i2s_L",  get_bits(0, 1, 24), UR_L);
      check_val("ur_lj_L",   get_bits(1, 0, 24), UR_L);
      run_slot(1'b1, 32);
      check_val("ur_i2s_R",  get_bits(0, 1, 24), UR_R);
    end

    // pair offered exactly on the left edge with the buffer empty
    send_pair(24'h5A0F33, 24'hC3817E);
    run_slot(1'b0, 32);
    check_val("byp_ur",      32'(ur_n), 32'd0);
    check_val("byp_i2s_L",   get_bits(0, 1, 24), 32'h5A0F33);
    check_val("byp_lj_L",    get_bits(1, 0, 24), 32'h5A0F33);
    send_pair(24'hFFFFFF, 24'hFFFFFF);
    run_slot(1'b1, 32);
    check_val("byp_i2s_R",   get_bits(0, 1, 24), 32'hC3817E);

    // 16-cycle slots are too short for 24-bit words
    run_slot(1'b0, 16);
    check_val("se_first",    32'(se_n), 32'd0);
    check_val("se_L_trunc",  get_bits(0, 1, 15), 32'h7FFF);
    run_slot(1'b1, 16);
    check_val("se_R_pulse",  32'(cap_se[0]), 32'd1);
    check_val("se_R_lj",     32'(se_lj_n), 32'd1);
    check_val("se_R_delay",  32'(cap_i2s[0]), 32'd0);
    check_val("se_R_i2s",    get_bits(0, 1, 15), 32'h7FFF);
    check_val("se_R_ljbits", get_bits(1, 0, 16), 32'hFFFF);
    run_slot(1'b0, 16);
    check_val("se_L2_se",    32'(se_n), 32'd1);
    check_val("se_L2_ur",    32'(ur_n), 32'd1);
    send_pair(24'h800001, 24'h7FFFFE);
    run_slot(1'b1, 32);
    check_val("se_R2_se",    32'(se_n), 32'd1);

    // full-length slots again; then reset in the middle of a right word
    send_pair(24'h111111, 24'h222222);
    run_slot(1'b0, 32);
    check_val("rec_se",      32'(se_n), 32'd0);
    check_val("rec_i2s_L",   get_bits(0, 1, 24), 32'h800001);
    check_val("rec_full",    32'(i2s_in_ready), 32'd0);
    run_slot(1'b1, 10);
    check_val("mid_bits",    get_bits(0, 1, 9), 32'h0FF);
    rst = 1'b1;
    tick();
    check_val("mr_sdout",    32'(i2s_sdout), 32'd0);
    check_val("mr_lj_sdout", 32'(lj_sdout), 32'd0);
    check_val("mr_ready",    32'(i2s_in_ready), 32'd1);
    tick();
    rst = 1'b0;
    run_slot(1'b1, 8);
    check_val("mr_fs",       32'(fs_n), 32'd0);
    check_val("mr_se",       32'(se_n), 32'd0);
    check_val("mr_quiet",    get_bits(0, 0, 8), 32'h0);
    run_slot(1'b0, 32);
    check_val("mr_unarm_ur", 32'(ur_n), 32'd0);
    check_val("mr_discard",  get_bits(0, 1, 24), 32'h0);
    check_val("mr_lj_disc",  get_bits(1, 0, 24), 32'h0);

    // reset with lrclk low must not fake a left edge
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    run_slot(1'b0, 8);
    check_val("lo_rst_fs",   32'(fs_n), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
